// File: rtl/hazard_timing_pipe_pkg.sv
// Shared encodings and the per-stage timing record for the hazard timing pipe.
// Tnew values never exceed 2; lw's extra cycle rides in a separate load flag.
package hazard_timing_pipe_pkg;

  localparam logic [4:0] RA_REG    = 5'd31;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wreg;
    logic       regwrite;
    logic       memwrite;
    logic [1:0] tnew;
  } stageRec_t;

  localparam int unsigned REC_W = $bits(stageRec_t);

  // Saturating decrement: Tnew counts down to zero and stays there.
  function automatic logic [1:0] tnewSat(input logic [1:0] t);
    return (t == TNEW_0) ? TNEW_0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/hazard_class_decode.sv
// Combinational instruction classifier: produces the D-stage timing record,
// the load flag and the operand use times.
module hazard_class_decode
  import hazard_timing_pipe_pkg::*;
(
  input  logic [31:0]      instr,
  output logic [REC_W-1:0] recOut,
  output logic             isLoad,
  output logic [1:0]       tuseRs,
  output logic [1:0]       tuseRt
);

  stageRec_t  rec;
  logic [5:0] op;
  logic [5:0] fn;
  logic       unusedShamt;

  assign op          = instr[31:26];
  assign fn          = instr[5:0];
  assign unusedShamt = ^instr[10:6];
  assign recOut      = rec;

  always_comb begin
    rec      = '0;
    rec.rs   = instr[25:21];
    rec.rt   = instr[20:16];
    tuseRs   = TUSE_NONE;
    tuseRt   = TUSE_NONE;
    isLoad   = 1'b0;
    case (op)
      OP_SPECIAL: begin
        if (fn == FN_ADDU || fn == FN_SUBU) begin
          tuseRs   = 2'd1;
          tuseRt   = 2'd1;
          rec.tnew = TNEW_2;
          rec.wreg = instr[15:11];
        end else if (fn == FN_JR) begin
          tuseRs = 2'd0;
        end
      end
      OP_ORI: begin
        tuseRs   = 2'd1;
        rec.tnew = TNEW_2;
        rec.wreg = instr[20:16];
      end
      OP_LUI: begin
        rec.tnew = TNEW_2;
        rec.wreg = instr[20:16];
      end
      OP_LW: begin
        tuseRs   = 2'd1;
        rec.tnew = TNEW_2;
        rec.wreg = instr[20:16];
        isLoad   = 1'b1;
      end
      OP_SW: begin
        tuseRs       = 2'd1;
        tuseRt       = 2'd2;
        rec.memwrite = 1'b1;
      end
      OP_BEQ: begin
        tuseRs = 2'd0;
        tuseRt = 2'd0;
      end
      OP_JAL: begin
        rec.tnew = TNEW_1;
        rec.wreg = RA_REG;
      end
      default: ;
    endcase
    // Writes to $0 are architecturally dead, so they must not trigger forwarding.
    rec.regwrite = (rec.wreg != 5'd0);
  end

endmodule

// File: rtl/hazard_timing_pipe.sv
// Producer side of the hazard interface: decodes the D-stage instruction and
// carries its Tnew/destination record through E, M and W.
module hazard_timing_pipe
  import hazard_timing_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrD,
  input  logic        flushE,
  output logic [1:0]  Tuse_rs,
  output logic [1:0]  Tuse_rt,
  output logic [1:0]  TnewD,
  output logic [4:0]  rsD,
  output logic [4:0]  rtD,
  output logic [4:0]  rsE,
  output logic [4:0]  rtE,
  output logic [1:0]  TnewE,
  output logic [1:0]  TnewM,
  output logic [1:0]  TnewW,
  output logic [4:0]  WriteRegE,
  output logic [4:0]  WriteRegM,
  output logic [4:0]  WriteRegW,
  output logic        RegWriteE,
  output logic        RegWriteM,
  output logic        RegWriteW,
  output logic        MemWriteM
);

  logic [REC_W-1:0] dRecBits;
  logic             dLoad;
  stageRec_t        dRec;
  stageRec_t        eD, eQ;
  stageRec_t        mD, mQ;
  stageRec_t        wD, wQ;
  logic             unusedFields;

  hazard_class_decode uDecode (
    .instr  (instrD),
    .recOut (dRecBits),
    .isLoad (dLoad),
    .tuseRs (Tuse_rs),
    .tuseRt (Tuse_rt)
  );

  assign dRec = dRecBits;

  always_comb begin
    eD = dRec;
    // lw behaves as Tnew 3 in D, so it enters E still needing two cycles.
    eD.tnew = dLoad ? TNEW_2 : tnewSat(dRec.tnew);
    if (flushE) begin
      eD = '0;
    end
  end

  always_comb begin
    mD      = eQ;
    mD.tnew = tnewSat(eQ.tnew);
    wD      = mQ;
    wD.tnew = tnewSat(mQ.tnew);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eQ <= '0;
      mQ <= '0;
      wQ <= '0;
    end else begin
      eQ <= eD;
      mQ <= mD;
      wQ <= wD;
    end
  end

  assign TnewD     = dRec.tnew;
  assign rsD       = instrD[25:21];
  assign rtD       = instrD[20:16];
  assign rsE       = eQ.rs;
  assign rtE       = eQ.rt;
  assign TnewE     = eQ.tnew;
  assign TnewM     = mQ.tnew;
  assign TnewW     = wQ.tnew;
  assign WriteRegE = eQ.wreg;
  assign WriteRegM = mQ.wreg;
  assign WriteRegW = wQ.wreg;
  assign RegWriteE = eQ.regwrite;
  assign RegWriteM = mQ.regwrite;
  assign RegWriteW = wQ.regwrite;
  assign MemWriteM = mQ.memwrite;

  assign unusedFields = ^{mQ.rs, mQ.rt, wQ.rs, wQ.rt, wQ.memwrite};

endmodule

// File: tb/tb_hazard_timing_pipe.sv
// Directed bench for hazard_timing_pipe: hand-computed timing/destination
// values checked with immediate assertions after each clock edge.
module tb_hazard_timing_pipe;

  logic        clk;
  logic        reset;
  logic [31:0] instrD;
  logic        flushE;
  logic [1:0]  Tuse_rs, Tuse_rt, TnewD;
  logic [4:0]  rsD, rtD, rsE, rtE;
  logic [1:0]  TnewE, TnewM, TnewW;
  logic [4:0]  WriteRegE, WriteRegM, WriteRegW;
  logic        RegWriteE, RegWriteM, RegWriteW, MemWriteM;

  int vectors = 0;
  int miscompares = 0;

  hazard_timing_pipe dut (
    .clk       (clk),
    .reset     (reset),
    .instrD    (instrD),
    .flushE    (flushE),
    .Tuse_rs   (Tuse_rs),
    .Tuse_rt   (Tuse_rt),
    .TnewD     (TnewD),
    .rsD       (rsD),
    .rtD       (rtD),
    .rsE       (rsE),
    .rtE       (rtE),
    .TnewE     (TnewE),
    .TnewM     (TnewM),
    .TnewW     (TnewW),
    .WriteRegE (WriteRegE),
    .WriteRegM (WriteRegM),
    .WriteRegW (WriteRegW),
    .RegWriteE (RegWriteE),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .MemWriteM (MemWriteM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset  = 1'b1;
    flushE = 1'b0;
    instrD = 32'd0;
    tick();
    tick();
    chk("rst TnewE", TnewE, 0);
    chk("rst TnewM", TnewM, 0);
    chk("rst TnewW", TnewW, 0);
    chk("rst RegWriteE", RegWriteE, 0);
    chk("rst RegWriteW", RegWriteW, 0);
    chk("rst MemWriteM", MemWriteM, 0);
    reset = 1'b0;

    // lw $1,0($0)
    instrD = iType(6'h23, 5'd0, 5'd1, 16'd0);
    #1;
    chk("lw TnewD", TnewD, 2);
    chk("lw Tuse_rs", Tuse_rs, 1);
    chk("lw Tuse_rt", Tuse_rt, 3);
    chk("lw rtD", rtD, 1);
    tick();
    chk("lw TnewE", TnewE, 2);
    chk("lw WriteRegE", WriteRegE, 1);
    chk("lw RegWriteE", RegWriteE, 1);

    // addu $2,$1,$3 stalls one cycle behind the load
    instrD = rType(5'd1, 5'd3, 5'd2, 6'h21);
    flushE = 1'b1;
    #1;
    chk("addu Tuse_rs", Tuse_rs, 1);
    chk("addu Tuse_rt", Tuse_rt, 1);
    chk("addu rsD", rsD, 1);
    chk("addu rtD", rtD, 3);
    tick();
    chk("bubble RegWriteE", RegWriteE, 0);
    chk("bubble TnewE", TnewE, 0);
    chk("bubble WriteRegE", WriteRegE, 0);
    chk("lw TnewM", TnewM, 1);
    chk("lw WriteRegM", WriteRegM, 1);
    chk("lw RegWriteM", RegWriteM, 1);
    flushE = 1'b0;
    tick();
    chk("addu TnewE", TnewE, 1);
    chk("addu WriteRegE", WriteRegE, 2);
    chk("addu rsE", rsE, 1);
    chk("addu rtE", rtE, 3);
    chk("bubble RegWriteM", RegWriteM, 0);
    chk("lw TnewW", TnewW, 0);
    chk("lw WriteRegW", WriteRegW, 1);
    chk("lw RegWriteW", RegWriteW, 1);

    // ori $5,$0,7
    instrD = iType(6'h0d, 5'd0, 5'd5, 16'd7);
    #1;
    chk("ori Tuse_rs", Tuse_rs, 1);
    chk("ori Tuse_rt", Tuse_rt, 3);
    tick();
    chk("ori TnewE", TnewE, 1);
    chk("ori WriteRegE", WriteRegE, 5);
    chk("addu TnewM", TnewM, 0);
    chk("addu WriteRegM", WriteRegM, 2);

    // sw $5,0($0)
    instrD = iType(6'h2b, 5'd0, 5'd5, 16'd0);
    #1;
    chk("sw Tuse_rt", Tuse_rt, 2);
    chk("sw Tuse_rs", Tuse_rs, 1);
    chk("sw TnewD", TnewD, 0);
    tick();
    chk("sw RegWriteE", RegWriteE, 0);
    chk("sw WriteRegE", WriteRegE, 0);
    chk("sw rtE", rtE, 5);
    chk("sw MemWriteM early", MemWriteM, 0);
    chk("ori TnewM", TnewM, 0);

    // jal 0
    instrD = {6'h03, 26'd0};
    #1;
    chk("jal TnewD", TnewD, 1);
    chk("jal Tuse_rs", Tuse_rs, 3);
    tick();
    chk("jal WriteRegE", WriteRegE, 31);
    chk("jal TnewE", TnewE, 0);
    chk("jal RegWriteE", RegWriteE, 1);
    chk("sw MemWriteM", MemWriteM, 1);
    chk("sw RegWriteM", RegWriteM, 0);
    chk("ori WriteRegW", WriteRegW, 5);
    chk("ori TnewW", TnewW, 0);
    chk("ori RegWriteW", RegWriteW, 1);

    // addu $0,$1,$2
    instrD = rType(5'd1, 5'd2, 5'd0, 6'h21);
    #1;
    chk("addu0 Tuse_rs", Tuse_rs, 1);
    chk("addu0 Tuse_rt", Tuse_rt, 1);
    tick();
    chk("addu0 RegWriteE", RegWriteE, 0);
    chk("addu0 WriteRegE", WriteRegE, 0);
    chk("addu0 TnewE", TnewE, 1);
    chk("jal TnewM", TnewM, 0);
    chk("jal WriteRegM", WriteRegM, 31);
    chk("sw gone MemWriteM", MemWriteM, 0);

    // lui $7,0x1234
    instrD = iType(6'h0f, 5'd0, 5'd7, 16'h1234);
    #1;
    chk("lui Tuse_rs", Tuse_rs, 3);
    chk("lui Tuse_rt", Tuse_rt, 3);
    chk("lui TnewD", TnewD, 2);
    tick();
    chk("lui RegWriteE", RegWriteE, 1);
    chk("lui WriteRegE", WriteRegE, 7);
    chk("addu0 TnewM", TnewM, 0);
    chk("jal TnewW", TnewW, 0);
    chk("jal WriteRegW", WriteRegW, 31);

    // j 0
    instrD = {6'h02, 26'd0};
    #1;
    chk("j Tuse_rs", Tuse_rs, 3);
    chk("j TnewD", TnewD, 0);
    tick();
    chk("j RegWriteE", RegWriteE, 0);
    chk("j WriteRegE", WriteRegE, 0);
    chk("lui TnewM", TnewM, 0);
    chk("lui WriteRegM", WriteRegM, 7);
    chk("addu0 RegWriteW", RegWriteW, 0);

    // nop
    instrD = 32'd0;
    tick();
    chk("nop RegWriteE", RegWriteE, 0);
    chk("nop TnewE", TnewE, 0);
    chk("lui WriteRegW", WriteRegW, 7);
    chk("lui RegWriteW", RegWriteW, 1);

    // D-only decodes: beq, jr, subu
    instrD = iType(6'h04, 5'd3, 5'd4, 16'd2);
    #1;
    chk("beq Tuse_rs", Tuse_rs, 0);
    chk("beq Tuse_rt", Tuse_rt, 0);
    chk("beq TnewD", TnewD, 0);
    instrD = rType(5'd31, 5'd0, 5'd0, 6'h08);
    #1;
    chk("jr Tuse_rs", Tuse_rs, 0);
    chk("jr Tuse_rt", Tuse_rt, 3);
    instrD = rType(5'd1, 5'd2, 5'd9, 6'h23);
    #1;
    chk("subu TnewD", TnewD, 2);
    chk("subu Tuse_rt", Tuse_rt, 1);

    // lw $6,4($2), then asynchronous reset while it sits in M
    tick();
    instrD = iType(6'h23, 5'd2, 5'd6, 16'd4);
    tick();
    instrD = 32'd0;
    tick();
    chk("lw6 TnewM", TnewM, 1);
    chk("lw6 WriteRegM", WriteRegM, 6);
    flushE = 1'b1;
    #3;
    reset  = 1'b1;
    instrD = iType(6'h0d, 5'd4, 5'd8, 16'd1);
    #1;
    chk("arst TnewM", TnewM, 0);
    chk("arst WriteRegM", WriteRegM, 0);
    chk("arst RegWriteM", RegWriteM, 0);
    chk("arst WriteRegW", WriteRegW, 0);
    chk("arst TnewE", TnewE, 0);
    chk("arst rsD", rsD, 4);
    #1;
    reset  = 1'b0;
    flushE = 1'b0;
    tick();
    chk("refill TnewE", TnewE, 1);
    chk("refill WriteRegE", WriteRegE, 8);
    instrD = 32'd0;
    tick();
    chk("refill WriteRegM", WriteRegM, 8);
    chk("refill TnewM", TnewM, 0);
    tick();
    chk("refill WriteRegW", WriteRegW, 8);
    chk("refill RegWriteW", RegWriteW, 1);
    chk("refill TnewW", TnewW, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
